spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
Autonomous master that drives the Nios SPI peripheral's 3-bit register port (addr 0 rxdata, 1 txdata, 2 status, 3 control, 5 slave-enable). It runs complete multi-byte, chip-select-framed transfers for two hardware requesters, arbitrating between them round-robin, so FPGA logic can reach SPI slaves 0 and 1 without CPU involvement. It sits between the requesters and the SPI core, in place of the CPU bus master.

Parameters:
POLL_LIMIT, 255, maximum status reads per wait before the transfer aborts with error.
SS_BITS, 2, width of the slave-enable word; requester i selects slave i (one-hot).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0 / req1  in  1  transfer request; held until done
len0 / len1  in  4  byte count minus 1 (0 means 1 byte, 15 means 16 bytes); sampled at grant
tx_data0 / tx_data1  in  8  next TX byte; show-ahead
tx_ack0 / tx_ack1  out  1  1-cycle pulse; tx_data consumed
rx_data  out  8  received byte, shared
rx_valid0 / rx_valid1  out  1  1-cycle pulse; rx_data valid for that requester
done0 / done1  out  1  1-cycle pulse at end of transfer
err0 / err1  out  1  valid with done; 1 means watchdog timeout or ROE
busy  out  1  transfer in progress
spi_select  out  1  SPI core chipselect
spi_mem_addr  out  3  register address
spi_data_from_cpu  out  16  write data
spi_read_n / spi_write_n  out  1  active-low strobes
spi_data_to_cpu  in  16  read data

Behaviour:
- Reset values: all pulse outputs, busy, spi_select = 0; spi_read_n = spi_write_n = 1; spi_mem_addr = 0; spi_data_from_cpu = 0; rx_data = 0; round-robin pointer favours req0.
- Bus access: spi_select is 1 and exactly one strobe is low for exactly 2 cycles, with address and data stable across both cycles. One idle cycle (select 0, strobes 1) follows every access. Read data is captured on the clock edge that ends cycle 2.
- States: IDLE -> ARB -> CLR_STAT -> SEL -> SSO_ON -> TX_WR -> POLL_RRDY -> RX_RD -> (next byte ? TX_WR : POLL_TMT) -> SSO_OFF -> DONE -> IDLE.
- IDLE: leave when req0 or req1 is 1.
- ARB: grant the single requester that is active. If both are active, grant the one not granted last. Latch len and the grant; busy = 1 from ARB through DONE.
- CLR_STAT: write addr 2, data 0. Clears stale RRDY/ROE/TOE/EOP.
- SEL: write addr 5, data = 1 << grant.
- SSO_ON: write addr 3, data 0x0400 (SSO=1, all IRQ enables 0).
- TX_WR: tx_ack_g pulses in the first cycle of the access; the data word is {8'h00, tx_data_g} sampled on that edge.
- POLL_RRDY: read addr 2 repeatedly.
  - Bit 7 (RRDY) = 1 -> RX_RD.
  - Bit 3 (ROE) = 1 -> set sticky error, continue.
  - After POLL_LIMIT reads without RRDY -> set error, go to SSO_OFF.
- RX_RD: read addr 0. rx_data = data[7:0] and rx_valid_g pulses the cycle after capture. Byte counter increments; the last byte is the one where count == len.
- POLL_TMT: read addr 2 until bit 5 (TMT) = 1, with the same POLL_LIMIT watchdog.
- SSO_OFF: write addr 3, data 0x0000. Always executed, including on abort, so CS deasserts.
- DONE: done_g pulses with err_g = sticky error, then the error is cleared. The pointer records the grant. The next ARB is no earlier than 1 cycle later.
- A req drop mid-transfer is ignored; the transfer completes. A req still held after done starts a new transfer, subject to round-robin.
- The poll counter is 8 bits and resets at each wait-state entry. It never wraps; the limit is compared with ==.
- Asynchronous reset mid-transfer returns to IDLE immediately with outputs at reset values. The SPI core is reset by the same reset_n.

Test Plan:
- req0=1, len0=0, tx 0xA5, SPI core MISO looped to MOSI -> accesses in order: w2, w5=0x0001, w3=0x0400, w1=0x00A5, poll r2, r0, poll r2, w3=0x0000. rx_data=0xA5 with rx_valid0; done0=1, err0=0.
- req1 with len1=3, bytes 01 02 03 04 -> 4 tx_ack1 pulses and 4 rx_valid1 pulses, in order; SS_n[1]=0 continuously from first to last byte.
- req0 and req1 asserted together from reset -> req0 served first, then req1. Both held again -> grants alternate 0,1,0,1.
- Stub SPI core status never sets RRDY, POLL_LIMIT=4 -> exactly 4 status reads, then w3=0x0000, done0 with err0=1; next request proceeds normally.
- Stub returns status 0x0088 (ROE+RRDY) -> byte delivered, done with err=1.
- reset_n low during the byte-2 poll -> busy=0, spi_select=0, strobes high on the same cycle; after release, a new req0 starts from CLR_STAT.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Autonomous bus master for the Nios SPI peripheral register port: runs chip-select framed
// multi-byte transfers for two hardware requesters, arbitrated round-robin.
module spi_xfer_sequencer #(
  parameter int unsigned POLL_LIMIT = 255,
  parameter int unsigned SS_BITS    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  len0,
  input  logic [3:0]  len1,
  input  logic [7:0]  tx_data0,
  input  logic [7:0]  tx_data1,
  output logic        tx_ack0,
  output logic        tx_ack1,
  output logic [7:0]  rx_data,
  output logic        rx_valid0,
  output logic        rx_valid1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        spi_select,
  output logic [2:0]  spi_mem_addr,
  output logic [15:0] spi_data_from_cpu,
  output logic        spi_read_n,
  output logic        spi_write_n,
  input  logic [15:0] spi_data_to_cpu
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_CLR_STAT, S_SEL, S_SSO_ON, S_TX_WR,
    S_POLL_RRDY, S_RX_RD, S_POLL_TMT, S_SSO_OFF, S_DONE
  } state_e;

  // Every register access spends two cycles with a strobe low, then one idle cycle.
  localparam logic [1:0] PH_ACT0 = 2'd0;
  localparam logic [1:0] PH_ACT1 = 2'd1;
  localparam logic [1:0] PH_IDLE = 2'd2;
  localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);

  function automatic logic is_acc(input state_e s);
    return s inside {S_CLR_STAT, S_SEL, S_SSO_ON, S_TX_WR, S_POLL_RRDY, S_RX_RD,
                     S_POLL_TMT, S_SSO_OFF};
  endfunction

  function automatic logic is_rd(input state_e s);
    return s inside {S_POLL_RRDY, S_RX_RD, S_POLL_TMT};
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    poll_cnt_q, poll_cnt_d;
  logic          rrdy_q, rrdy_d;
  logic          tmt_q, tmt_d;
  logic          err_q, err_d;

  logic          busy_q, busy_d;
  logic          sel_q, sel_d;
  logic [2:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic [1:0]    tx_ack_q, tx_ack_d;
  logic [1:0]    rx_valid_q, rx_valid_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_o_q, err_o_d;
  logic [7:0]    rx_data_q, rx_data_d;

  logic [SS_BITS-1:0] ss_word;
  logic               bus_act;
  logic               last_phase;
  logic               unused_rdata_hi;

  assign ss_word         = SS_BITS'(1) << grant_q;
  assign last_phase      = (phase_q == PH_IDLE);
  assign unused_rdata_hi = ^spi_data_to_cpu[15:8];

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    grant_d    = grant_q;
    last_d     = last_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    poll_cnt_d = poll_cnt_q;
    rrdy_d     = rrdy_q;
    tmt_d      = tmt_q;
    err_d      = err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = '0;

    if (is_acc(state_q)) begin
      phase_d = last_phase ? PH_ACT0 : phase_q + 2'd1;
      // Read data is taken on the edge that closes the second strobe cycle.
      if (phase_q == PH_ACT1 && is_rd(state_q)) begin
        rrdy_d = spi_data_to_cpu[7];
        tmt_d  = spi_data_to_cpu[5];
        if (state_q != S_RX_RD) poll_cnt_d = poll_cnt_q + 8'd1;
        if (state_q == S_POLL_RRDY && spi_data_to_cpu[3]) err_d = 1'b1;
        if (state_q == S_RX_RD) begin
          rx_data_d           = spi_data_to_cpu[7:0];
          rx_valid_d[grant_q] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: if (req0 || req1) state_d = S_ARB;
      S_ARB: begin
        byte_cnt_d = '0;
        if (req0 || req1) begin
          grant_d = (req0 && req1) ? ~last_q : req1;
          len_d   = grant_d ? len1 : len0;
          state_d = S_CLR_STAT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR_STAT: if (last_phase) state_d = S_SEL;
      S_SEL:      if (last_phase) state_d = S_SSO_ON;
      S_SSO_ON:   if (last_phase) state_d = S_TX_WR;
      S_TX_WR:    if (last_phase) state_d = S_POLL_RRDY;
      S_POLL_RRDY: if (last_phase) begin
        if (rrdy_q) begin
          state_d = S_RX_RD;
        end else if (poll_cnt_q == POLL_MAX) begin
          err_d   = 1'b1;
          state_d = S_SSO_OFF;
        end
      end
      S_RX_RD: if (last_phase) begin
        if (byte_cnt_q == len_q) begin
          state_d = S_POLL_TMT;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          state_d    = S_TX_WR;
        end
      end
      S_POLL_TMT: if (last_phase) begin
        if (tmt_q) begin
          state_d = S_SSO_OFF;
        end else if (poll_cnt_q == POLL_MAX) begin
          err_d   = 1'b1;
          state_d = S_SSO_OFF;
        end
      end
      S_SSO_OFF: if (last_phase) state_d = S_DONE;
      S_DONE: begin
        last_d  = grant_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Each wait state starts its watchdog afresh.
    if (state_d != state_q) poll_cnt_d = '0;
  end

  // Bus and pulse outputs are registered images of the next state and phase.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    bus_act  = is_acc(state_d) && (phase_d != PH_IDLE);
    sel_d    = bus_act;
    rd_n_d   = !(bus_act && is_rd(state_d));
    wr_n_d   = !(bus_act && !is_rd(state_d));
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_ack_d = '0;
    done_d   = '0;
    err_o_d  = '0;

    if (is_acc(state_d) && phase_d == PH_ACT0) begin
      case (state_d)
        S_CLR_STAT: begin addr_d = 3'd2; wdata_d = 16'h0000;      end
        S_SEL:      begin addr_d = 3'd5; wdata_d = 16'(ss_word);  end
        S_SSO_ON:   begin addr_d = 3'd3; wdata_d = 16'h0400;      end
        S_TX_WR: begin
          addr_d            = 3'd1;
          wdata_d           = {8'h00, grant_q ? tx_data1 : tx_data0};
          tx_ack_d[grant_q] = 1'b1;
        end
        S_POLL_RRDY, S_POLL_TMT: begin addr_d = 3'd2; wdata_d = 16'h0000; end
        S_RX_RD:    begin addr_d = 3'd0; wdata_d = 16'h0000;      end
        S_SSO_OFF:  begin addr_d = 3'd3; wdata_d = 16'h0000;      end
        default: ;
      endcase
    end

    if (state_d == S_DONE) begin
      done_d[grant_q]  = 1'b1;
      err_o_d[grant_q] = err_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_ACT0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      len_q      <= '0;
      byte_cnt_q <= '0;
      poll_cnt_q <= '0;
      rrdy_q     <= 1'b0;
      tmt_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      tx_ack_q   <= '0;
      rx_valid_q <= '0;
      done_q     <= '0;
      err_o_q    <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      rrdy_q     <= rrdy_d;
      tmt_q      <= tmt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      err_o_q    <= err_o_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign tx_ack0           = tx_ack_q[0];
  assign tx_ack1           = tx_ack_q[1];
  assign rx_valid0         = rx_valid_q[0];
  assign rx_valid1         = rx_valid_q[1];
  assign done0             = done_q[0];
  assign done1             = done_q[1];
  assign err0              = err_o_q[0];
  assign err1              = err_o_q[1];
  assign rx_data           = rx_data_q;
  assign busy              = busy_q;
  assign spi_select        = sel_q;
  assign spi_mem_addr      = addr_q;
  assign spi_data_from_cpu = wdata_q;
  assign spi_read_n        = rd_n_q;
  assign spi_write_n       = wr_n_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a behavioural SPI-core stub with MISO looped to MOSI,
// a bus monitor that logs accesses and pulses, and hand-computed expectations.
module tb_spi_xfer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [3:0]  len0, len1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_ack0, tx_ack1;
  logic [7:0]  rx_data;
  logic        rx_valid0, rx_valid1;
  logic        done0, done1, err0, err1;
  logic        busy;
  logic        spi_select;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data_from_cpu;
  logic        spi_read_n, spi_write_n;
  logic [15:0] spi_data_to_cpu;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(.POLL_LIMIT(4), .SS_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_ack0(tx_ack0), .tx_ack1(tx_ack1),
    .rx_data(rx_data), .rx_valid0(rx_valid0), .rx_valid1(rx_valid1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .busy(busy),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
    .spi_data_from_cpu(spi_data_from_cpu), .spi_read_n(spi_read_n),
    .spi_write_n(spi_write_n), .spi_data_to_cpu(spi_data_to_cpu)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Stub status mode: 0 normal (RRDY after poll_delay reads), 1 never RRDY, 2 ROE+RRDY.
  int          mode;
  int          poll_delay;
  logic [7:0]  tx0_mem [16];
  logic [7:0]  tx1_mem [16];

  logic        pending;
  logic [7:0]  rx_byte;
  int          nr_cnt;
  logic        sso;
  logic [1:0]  ssreg;
  logic [15:0] stat;

  int          ack0_cnt = 0, ack1_cnt = 0;
  int          proto_err = 0, ss_gap = 0;
  logic [19:0] acc_log [$];
  logic [7:0]  rx0_log [$];
  logic [7:0]  rx1_log [$];
  logic [1:0]  done_log [$];

  assign tx_data0 = tx0_mem[ack0_cnt[3:0]];
  assign tx_data1 = tx1_mem[ack1_cnt[3:0]];

  always_comb begin
    stat = 16'h0020;
    if (pending) begin
      case (mode)
        1:       stat = 16'h0000;
        2:       stat = 16'h0088;
        default: stat = (nr_cnt >= poll_delay) ? 16'h0080 : 16'h0000;
      endcase
    end
    if (spi_mem_addr == 3'd0)      spi_data_to_cpu = {8'h00, rx_byte};
    else if (spi_mem_addr == 3'd2) spi_data_to_cpu = stat;
    else                           spi_data_to_cpu = 16'h0000;
  end

  // Bus monitor and stub state; access entries are {write, addr, write data}.
  logic        prev_act = 1'b0;
  int          run_len = 0;
  logic [19:0] cur = '0;
  always @(negedge clk) begin
    logic        act;
    logic [19:0] ent;
    if (!reset_n) begin
      prev_act = 1'b0; run_len = 0;
      pending = 1'b0; rx_byte = 8'h00; nr_cnt = 0; sso = 1'b0; ssreg = 2'b00;
    end else begin
      act = spi_select && !(spi_read_n && spi_write_n);
      ent = {!spi_write_n, spi_mem_addr, spi_write_n ? 16'h0000 : spi_data_from_cpu};
      if (spi_select && (spi_read_n == spi_write_n)) proto_err++;
      if (!spi_select && !(spi_read_n && spi_write_n)) proto_err++;
      if (act && !prev_act) begin
        cur = ent; run_len = 1; acc_log.push_back(ent);
      end else if (act) begin
        run_len++;
        if (ent != cur) proto_err++;
      end else if (prev_act) begin
        if (run_len != 2) proto_err++;
        case (cur[19:16])
          4'b1001: begin pending = 1'b1; rx_byte = cur[7:0]; nr_cnt = 0; end
          4'b1101: ssreg = cur[1:0];
          4'b1011: sso = cur[10];
          4'b0010: if (pending && nr_cnt < poll_delay) nr_cnt++;
          4'b0000: pending = 1'b0;
          default: ;
        endcase
      end
      prev_act = act;
      if (tx_ack0) ack0_cnt++;
      if (tx_ack1) ack1_cnt++;
      if (rx_valid0) rx0_log.push_back(rx_data);
      if (rx_valid1) rx1_log.push_back(rx_data);
      if ((tx_ack0 || rx_valid0) && !(sso && ssreg == 2'b01)) ss_gap++;
      if ((tx_ack1 || rx_valid1) && !(sso && ssreg == 2'b10)) ss_gap++;
      if (done0 && done1) proto_err++;
      if (done0 || done1) done_log.push_back({done1, done1 ? err1 : err0});
    end
  end

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? 32'(acc_log[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] done_at(input int i);
    return (i < done_log.size()) ? 32'(done_log[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] rx0_at(input int i);
    return (i < rx0_log.size()) ? 32'(rx0_log[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] rx1_at(input int i);
    return (i < rx1_log.size()) ? 32'(rx1_log[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_done(input int n, input string tag);
    int cyc = 0;
    while (done_log.size() < n && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    if (done_log.size() < n) check(tag, done_log.size(), n);
  endtask

  initial begin
    int lb, nd, nr, k, cyc;
    logic [19:0] exp_seq [$];

    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    mode = 0; poll_delay = 0;
    for (int i = 0; i < 16; i++) begin tx0_mem[i] = 8'h00; tx1_mem[i] = 8'h00; end
    repeat (3) @(posedge clk); #1;

    check("rst_busy", busy, 1'b0);
    check("rst_select", spi_select, 1'b0);
    check("rst_read_n", spi_read_n, 1'b1);
    check("rst_write_n", spi_write_n, 1'b1);
    check("rst_addr", spi_mem_addr, 3'd0);
    check("rst_wdata", spi_data_from_cpu, 16'h0000);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {tx_ack0, tx_ack1, rx_valid0, rx_valid1, done0, done1, err0, err1}, 8'h00);

    // Both requesters held out of reset: grants alternate starting with req0.
    tx0_mem[0] = 8'h11; tx0_mem[1] = 8'h33; tx1_mem[0] = 8'h22; tx1_mem[1] = 8'h44;
    poll_delay = 1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    wait_done(4, "rr_timeout");
    req0 = 1'b0; req1 = 1'b0;
    check("rr_grant0", done_at(0), 2'b00);
    check("rr_grant1", done_at(1), 2'b10);
    check("rr_grant2", done_at(2), 2'b00);
    check("rr_grant3", done_at(3), 2'b10);
    check("rr_rx0_a", rx0_at(0), 8'h11);
    check("rr_rx0_b", rx0_at(1), 8'h33);
    check("rr_rx1_a", rx1_at(0), 8'h22);
    check("rr_rx1_b", rx1_at(1), 8'h44);

    // Single byte on req0: exact register access sequence.
    repeat (2) @(posedge clk); #1;
    poll_delay = 0;
    lb = acc_log.size(); nd = done_log.size(); nr = rx0_log.size();
    tx0_mem[ack0_cnt[3:0]] = 8'hA5; len0 = 4'd0; req0 = 1'b1;
    wait_done(nd + 1, "one_timeout");
    req0 = 1'b0;
    exp_seq = '{20'hA0000, 20'hD0001, 20'hB0400, 20'h900A5,
                20'h20000, 20'h00000, 20'h20000, 20'hB0000};
    check("one_nacc", acc_log.size() - lb, 8);
    for (int i = 0; i < 8; i++) check($sformatf("one_acc%0d", i), acc_at(lb + i), exp_seq[i]);
    check("one_rx", rx0_at(nr), 8'hA5);
    check("one_done", done_at(nd), 2'b00);

    // Four bytes on req1 with slow RRDY; chip select must hold across all bytes.
    repeat (2) @(posedge clk); #1;
    poll_delay = 2;
    nd = done_log.size(); nr = rx1_log.size(); k = ack1_cnt;
    for (int i = 0; i < 4; i++) tx1_mem[4'(k + i)] = 8'(i + 1);
    len1 = 4'd3; req1 = 1'b1;
    wait_done(nd + 1, "multi_timeout");
    req1 = 1'b0;
    check("multi_acks", ack1_cnt - k, 4);
    check("multi_nrx", rx1_log.size() - nr, 4);
    for (int i = 0; i < 4; i++) check($sformatf("multi_rx%0d", i), rx1_at(nr + i), 8'(i + 1));
    check("multi_done", done_at(nd), 2'b10);
    check("multi_ss_gap", ss_gap, 0);

    // RRDY never set: exactly four status reads, then CS off and an error.
    repeat (2) @(posedge clk); #1;
    mode = 1; poll_delay = 0;
    lb = acc_log.size(); nd = done_log.size(); nr = rx0_log.size();
    tx0_mem[ack0_cnt[3:0]] = 8'hE1; len0 = 4'd0; req0 = 1'b1;
    wait_done(nd + 1, "wdog_timeout");
    req0 = 1'b0;
    check("wdog_nacc", acc_log.size() - lb, 9);
    for (int i = 4; i < 8; i++) check($sformatf("wdog_poll%0d", i - 4), acc_at(lb + i), 20'h20000);
    check("wdog_sso_off", acc_at(lb + 8), 20'hB0000);
    check("wdog_done", done_at(nd), 2'b01);
    check("wdog_no_rx", rx0_log.size() - nr, 0);

    repeat (2) @(posedge clk); #1;
    mode = 0;
    nd = done_log.size(); nr = rx0_log.size();
    tx0_mem[ack0_cnt[3:0]] = 8'h5A; req0 = 1'b1;
    wait_done(nd + 1, "recover_timeout");
    req0 = 1'b0;
    check("recover_done", done_at(nd), 2'b00);
    check("recover_rx", rx0_at(nr), 8'h5A);

    // ROE together with RRDY: byte still delivered, error reported.
    repeat (2) @(posedge clk); #1;
    mode = 2;
    nd = done_log.size(); nr = rx1_log.size();
    tx1_mem[ack1_cnt[3:0]] = 8'h3C; len1 = 4'd0; req1 = 1'b1;
    wait_done(nd + 1, "roe_timeout");
    req1 = 1'b0;
    check("roe_rx", rx1_at(nr), 8'h3C);
    check("roe_done", done_at(nd), 2'b11);

    // Asynchronous reset during the second byte's status poll.
    repeat (2) @(posedge clk); #1;
    mode = 0; poll_delay = 2;
    nd = done_log.size(); k = ack0_cnt;
    tx0_mem[4'(k)] = 8'h10; tx0_mem[4'(k + 1)] = 8'h20; len0 = 4'd1; req0 = 1'b1;
    cyc = 0;
    while (ack0_cnt < k + 2 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check("mid_second_ack", ack0_cnt - k, 2);
    repeat (3) @(posedge clk); #1;
    check("mid_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_select", spi_select, 1'b0);
    check("mid_strobes", {spi_read_n, spi_write_n}, 2'b11);
    req0 = 1'b0;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("mid_no_done", done_log.size() - nd, 0);
    lb = acc_log.size(); nr = rx0_log.size();
    tx0_mem[ack0_cnt[3:0]] = 8'h77; len0 = 4'd0; req0 = 1'b1;
    wait_done(nd + 1, "after_rst_timeout");
    req0 = 1'b0;
    check("after_rst_first", acc_at(lb), 20'hA0000);
    check("after_rst_done", done_at(nd), 2'b00);
    check("after_rst_rx", rx0_at(nr), 8'h77);

    repeat (4) @(posedge clk); #1;
    check("bus_protocol", proto_err, 0);
    check("cs_continuity", ss_gap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
